// File: rtl/sensor_buffer_ctrl.sv
// Capture engine: handshakes sensor samples into a DEPTH-entry buffer, flags full via
// interrupt, and serves buffered words combinationally to the wrapper's read path.
module sensor_buffer_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [ADDR_W-1:0] sctrl_addr,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sctrl_interrupt,
  output logic [DATA_W-1:0] sctrl_out,
  output logic              sensor_en,
  output logic [ADDR_W:0]   sample_cnt
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StFull} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                irq_q, irq_d;
  logic                sensor_en_q;
  logic                accept;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    accept  = 1'b0;
    if (sctrl_clear) begin
      // Clear wins over enable and any sample presented this cycle.
      state_d = StIdle;
      wptr_d  = '0;
      cnt_d   = '0;
      irq_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sctrl_en) state_d = StCapture;
        end
        StCapture: begin
          if (sensor_ready) begin
            accept = 1'b1;
            wptr_d = wptr_q + ADDR_W'(1);
            cnt_d  = cnt_q + (ADDR_W + 1)'(1);
          end
          // A sample arriving with enable falling is still taken before pausing.
          if (sensor_ready && (wptr_q == LastIdx)) begin
            state_d = StFull;
            irq_d   = 1'b1;
          end else if (!sctrl_en) begin
            state_d = StIdle;
          end
        end
        StFull: begin
          state_d = StFull;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
      sensor_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
      // Registered from next state so it tracks state_q exactly.
      sensor_en_q <= (state_d == StCapture);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wptr_q] <= sensor_out;
    end
  end

  assign sctrl_out       = mem_q[sctrl_addr];
  assign sctrl_interrupt = irq_q;
  assign sensor_en       = sensor_en_q;
  assign sample_cnt      = cnt_q;

endmodule

// File: tb/tb_sensor_buffer_ctrl.sv
// Directed bench for sensor_buffer_ctrl: fill, full hold, clear, pause, clear collision
// and mid-capture reset, each with hand-computed expectations.
module tb_sensor_buffer_ctrl;

  logic        clk;
  logic        rstn;
  logic        sctrl_en;
  logic        sctrl_clear;
  logic [5:0]  sctrl_addr;
  logic        sensor_ready;
  logic [31:0] sensor_out;
  logic        sctrl_interrupt;
  logic [31:0] sctrl_out;
  logic        sensor_en;
  logic [6:0]  sample_cnt;

  int total;
  int bad;

  sensor_buffer_ctrl #(
    .DATA_W(32),
    .DEPTH (64),
    .ADDR_W(6)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sctrl_en       (sctrl_en),
    .sctrl_clear    (sctrl_clear),
    .sctrl_addr     (sctrl_addr),
    .sensor_ready   (sensor_ready),
    .sensor_out     (sensor_out),
    .sctrl_interrupt(sctrl_interrupt),
    .sctrl_out      (sctrl_out),
    .sensor_en      (sensor_en),
    .sample_cnt     (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input logic [5:0] a);
    sctrl_addr = a;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; sctrl_en = 1'b0; sctrl_clear = 1'b0; sctrl_addr = '0;
    sensor_ready = 1'b0; sensor_out = '0;
    tick(); tick();
    rstn = 1'b1;
    #1;
    total++;
    if (sample_cnt !== 7'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", sample_cnt); end
    total++;
    if (sctrl_interrupt !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", sctrl_interrupt); end
    total++;
    if (sensor_en !== 1'b0) begin bad++; $display("FAIL reset_sensor_en got=%b want=0", sensor_en); end
    read_at(6'd17);
    total++;
    if (sctrl_out !== 32'h0) begin bad++; $display("FAIL reset_read got=%h want=0", sctrl_out); end
  endtask

  task automatic test_fill();
    sctrl_en = 1'b1;
    tick();
    total++;
    if (sensor_en !== 1'b1) begin bad++; $display("FAIL fill_sensor_en got=%b want=1", sensor_en); end
    for (int i = 0; i < 64; i++) begin
      sensor_ready = 1'b1;
      sensor_out   = 32'h1000 + 32'(i);
      if (i == 0) begin
        // Entry being written still shows its old value this cycle.
        read_at(6'd0);
        total++;
        if (sctrl_out !== 32'h0) begin bad++; $display("FAIL same_cycle_read got=%h want=0", sctrl_out); end
      end
      tick();
      sensor_ready = 1'b0;
      if (i == 62) begin
        total++;
        if (sctrl_interrupt !== 1'b0) begin bad++; $display("FAIL early_irq got=%b want=0", sctrl_interrupt); end
      end
      if (i < 63) tick();
    end
    total++;
    if (sctrl_interrupt !== 1'b1) begin bad++; $display("FAIL full_irq got=%b want=1", sctrl_interrupt); end
    total++;
    if (sensor_en !== 1'b0) begin bad++; $display("FAIL full_sensor_en got=%b want=0", sensor_en); end
    total++;
    if (sample_cnt !== 7'd64) begin bad++; $display("FAIL full_cnt got=%0d want=64", sample_cnt); end
    read_at(6'd0);
    total++;
    if (sctrl_out !== 32'h1000) begin bad++; $display("FAIL read0 got=%h want=1000", sctrl_out); end
    read_at(6'd37);
    total++;
    if (sctrl_out !== 32'h1025) begin bad++; $display("FAIL read37 got=%h want=1025", sctrl_out); end
    read_at(6'd63);
    total++;
    if (sctrl_out !== 32'h103F) begin bad++; $display("FAIL read63 got=%h want=103f", sctrl_out); end
  endtask

  task automatic test_full_hold();
    sensor_ready = 1'b1;
    sensor_out   = 32'hDEAD;
    for (int i = 0; i < 10; i++) tick();
    sensor_ready = 1'b0;
    read_at(6'd0);
    total++;
    if (sctrl_out !== 32'h1000) begin bad++; $display("FAIL hold_read0 got=%h want=1000", sctrl_out); end
    total++;
    if (sctrl_interrupt !== 1'b1) begin bad++; $display("FAIL hold_irq got=%b want=1", sctrl_interrupt); end
    total++;
    if (sample_cnt !== 7'd64) begin bad++; $display("FAIL hold_cnt got=%0d want=64", sample_cnt); end
  endtask

  task automatic test_clear();
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    total++;
    if (sctrl_interrupt !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b want=0", sctrl_interrupt); end
    total++;
    if (sample_cnt !== 7'd0) begin bad++; $display("FAIL clear_cnt got=%0d want=0", sample_cnt); end
    read_at(6'd5);
    total++;
    if (sctrl_out !== 32'h1005) begin bad++; $display("FAIL clear_keeps_data got=%h want=1005", sctrl_out); end
    tick();  // IDLE -> CAPTURE with en still high
    for (int i = 0; i < 3; i++) begin
      sensor_ready = 1'b1;
      sensor_out   = 32'hA0 + 32'(i);
      tick();
    end
    sensor_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      read_at(6'(i));
      total++;
      if (sctrl_out !== 32'hA0 + 32'(i)) begin
        bad++; $display("FAIL recap_read%0d got=%h want=%h", i, sctrl_out, 32'hA0 + 32'(i));
      end
    end
    read_at(6'd3);
    total++;
    if (sctrl_out !== 32'h1003) begin bad++; $display("FAIL recap_read3 got=%h want=1003", sctrl_out); end
  endtask

  task automatic test_pause();
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      sensor_ready = 1'b1;
      sensor_out   = 32'h200 + 32'(i);
      tick();
    end
    sensor_out = 32'h20A;
    sctrl_en   = 1'b0;
    tick();
    sensor_ready = 1'b0;
    total++;
    if (sample_cnt !== 7'd11) begin bad++; $display("FAIL pause_cnt got=%0d want=11", sample_cnt); end
    total++;
    if (sensor_en !== 1'b0) begin bad++; $display("FAIL pause_sensor_en got=%b want=0", sensor_en); end
    read_at(6'd10);
    total++;
    if (sctrl_out !== 32'h20A) begin bad++; $display("FAIL pause_read10 got=%h want=20a", sctrl_out); end
    sensor_ready = 1'b1;
    sensor_out   = 32'hBAD;
    tick();  // idle: must be ignored
    sensor_ready = 1'b0;
    sctrl_en     = 1'b1;
    tick();
    sensor_ready = 1'b1;
    sensor_out   = 32'h2BB;
    tick();
    sensor_ready = 1'b0;
    read_at(6'd11);
    total++;
    if (sctrl_out !== 32'h2BB) begin bad++; $display("FAIL resume_read11 got=%h want=2bb", sctrl_out); end
    total++;
    if (sample_cnt !== 7'd12) begin bad++; $display("FAIL resume_cnt got=%0d want=12", sample_cnt); end
  endtask

  task automatic test_clear_collision();
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      sensor_ready = 1'b1;
      sensor_out   = 32'h300 + 32'(i);
      tick();
    end
    sensor_out  = 32'h3FF;
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear  = 1'b0;
    sensor_ready = 1'b0;
    total++;
    if (sample_cnt !== 7'd0) begin bad++; $display("FAIL coll_cnt got=%0d want=0", sample_cnt); end
    read_at(6'd20);
    total++;
    if (sctrl_out !== 32'h1014) begin bad++; $display("FAIL coll_dropped got=%h want=1014", sctrl_out); end
    tick();
    sensor_ready = 1'b1;
    sensor_out   = 32'h3AA;
    tick();
    sensor_ready = 1'b0;
    read_at(6'd0);
    total++;
    if (sctrl_out !== 32'h3AA) begin bad++; $display("FAIL coll_next0 got=%h want=3aa", sctrl_out); end
  endtask

  task automatic test_reset_mid();
    int nz;
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin
      sensor_ready = 1'b1;
      sensor_out   = 32'h400 + 32'(i);
      tick();
    end
    total++;
    if (sample_cnt !== 7'd30) begin bad++; $display("FAIL mid_cnt30 got=%0d want=30", sample_cnt); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    sensor_ready = 1'b0;
    sctrl_en     = 1'b0;
    total++;
    if (sample_cnt !== 7'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", sample_cnt); end
    total++;
    if (sensor_en !== 1'b0) begin bad++; $display("FAIL mid_rst_sensor_en got=%b want=0", sensor_en); end
    total++;
    if (sctrl_interrupt !== 1'b0) begin bad++; $display("FAIL mid_rst_irq got=%b want=0", sctrl_interrupt); end
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      read_at(6'(i));
      if (sctrl_out !== 32'h0) nz++;
    end
    total++;
    if (nz !== 0) begin bad++; $display("FAIL mid_rst_mem nonzero_entries=%0d want=0", nz); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_full_hold();
    test_clear();
    test_pause();
    test_clear_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
